cpu_load_store_unit: RTL and testbench
======================================

CPU_LOAD_STORE_UNIT -- requirements
Module: cpu_load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles a bus request waits for BusReady before being aborted.
REQ-002 SHALL have port CoreClock  input  1  the single clock; all state advances on its rising edge.
REQ-003 SHALL have port CoreReset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port LsuValid  input  1  core presents a memory operation.
REQ-005 SHALL have port LsuOp  input  3  operation code: LB, LH, LW, LBU, LHU, SB, SH, SW.
REQ-006 SHALL have port LsuAddress  input  32  byte address.
REQ-007 SHALL have port LsuStoreData  input  32  store data, right-aligned.
REQ-008 SHALL have port LsuBusy  output  1  unit cannot accept a new operation.
REQ-009 SHALL have port LsuDone  output  1  one-cycle completion pulse.
REQ-010 SHALL have port LsuLoadData  output  32  extended load result, valid while LsuDone is high.
REQ-011 SHALL have port LsuFault  output  2  completion status, valid while LsuDone is high: 0 OK, 1 misaligned, 2 bus timeout.
REQ-012 SHALL have port BusRequest  output  1  request to the memory controller.
REQ-013 SHALL have port BusWrite  output  1  1 = write, 0 = read.
REQ-014 SHALL have port BusAddress  output  32  word address, with bits [1:0] forced to 0.
REQ-015 SHALL have port BusWriteData  output  32  lane-steered write data.
REQ-016 SHALL have port BusByteMask  output  4  active write byte lanes.
REQ-017 SHALL have port BusReady  input  1  controller completes the request this cycle.
REQ-018 SHALL have port BusReadData  input  32  read word, valid when BusReady is high.

Function
REQ-019 SHALL implement a three-state FSM with states IDLE, REQUEST and COMPLETE.
REQ-020 In IDLE, LsuValid SHALL be accepted and all inputs captured; LsuBusy SHALL be 0 only in IDLE.
REQ-021 Misaligned accepts (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) SHALL bypass the bus, go to COMPLETE, and report LsuFault=1.
REQ-022 Aligned accepts SHALL go to REQUEST; all Bus* outputs SHALL be registered and driven from the cycle after accept.
REQ-023 In REQUEST, BusRequest=1 and all bus fields SHALL be held stable until BusReady=1 or timeout.
REQ-024 On BusReady=1, BusReadData SHALL be captured, lane-extracted and extended, and the FSM SHALL go to COMPLETE.
REQ-025 The timeout counter SHALL clear on entry to REQUEST; reaching TIMEOUT_CYCLES without BusReady SHALL drop BusRequest and go to COMPLETE with LsuFault=2.
REQ-026 COMPLETE SHALL assert LsuDone for exactly one cycle, then return to IDLE; a new accept is possible the following cycle.
REQ-027 Minimum latency SHALL be 2 cycles from accept to LsuDone (accept N, BusRequest N+1 with BusReady=1, LsuDone N+2).
REQ-028 Store byte lanes: SB SHALL replicate the byte to all lanes with mask 1<<addr[1:0]; SH SHALL replicate the halfword with mask 0011 or 1100; SW SHALL use mask 1111.
REQ-029 Read byte mask SHALL be 0000 and BusWrite SHALL be 0 for loads.
REQ-030 Loads: LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend the selected lane; LW SHALL pass the word through; stores SHALL return LsuLoadData=0.
REQ-031 LsuValid while busy SHALL be ignored; the core is responsible for holding it.
REQ-032 BusReady outside REQUEST SHALL be ignored.

Reset
REQ-033 CoreReset_n low SHALL immediately force IDLE, clear the timeout counter, and drive all outputs to 0, including mid-request (BusRequest drops asynchronously).
REQ-034 Deassertion SHALL be synchronised by the parent; the first accept is possible on the first CoreClock edge with reset high.

Structure
REQ-035 Package trashbin_lsu_pkg SHALL hold the LsuOp encoding enum, the FSM state enum, and the fault code constants.
REQ-036 Sub-module lsu_align (combinational) SHALL perform store lane steering, mask generation, load extraction and extension.

Verification
REQ-037 LW at 0x100, BusReady in the first cycle, BusReadData=0xDEADBEEF -> LsuDone 2 cycles after accept, LsuLoadData=0xDEADBEEF, LsuFault=0.
REQ-038 LB at 0x103, BusReadData=0x80112233 -> BusAddress=0x100, LsuLoadData=0xFFFFFF80; the same access with LBU -> 0x00000080.
REQ-039 SH at 0x202 with data 0x0000ABCD, BusReady delayed 3 cycles -> bus fields stable for 4 cycles, BusWriteData=0xABCDABCD, BusByteMask=1100.
REQ-040 LW at 0x101 -> no BusRequest, LsuDone after 1 cycle with LsuFault=1.
REQ-041 SW with BusReady never asserted, TIMEOUT_CYCLES=4 -> BusRequest high for 4 cycles, then LsuDone with LsuFault=2.
REQ-042 CoreReset_n pulsed low during REQUEST -> BusRequest=0 immediately, no LsuDone, next LW completes normally.

Source files
------------

// File: rtl/trashbin_lsu_pkg.sv
// ---------------------------------------------------------------------------
// trashbin_lsu_pkg
// Shared types for the load/store unit: the core-side operation encoding,
// the control FSM states, the completion fault codes, and small decode
// helpers used by both the control path and the lane aligner.
// ---------------------------------------------------------------------------
package trashbin_lsu_pkg;

  // Core-side operation encoding, as presented on LsuOp.
  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } lsu_op_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQUEST  = 2'd1,
    ST_COMPLETE = 2'd2
  } lsu_state_e;

  // Completion status reported on LsuFault.
  localparam logic [1:0] FAULT_OK         = 2'd0;
  localparam logic [1:0] FAULT_MISALIGNED = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT    = 2'd2;

  function automatic logic is_store_op(lsu_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Halfword accesses need an even address, word accesses a multiple of 4.
  function automatic logic is_misaligned(lsu_op_e op, logic [1:0] byte_off);
    logic mis;
    mis = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: mis = byte_off[0];
      OP_LW, OP_SW:         mis = (byte_off != 2'b00);
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane logic for the load/store unit.
//   op         : operation (lsu_op_e encoding)
//   byte_off   : address bits [1:0]
//   store_data : right-aligned store data from the core
//   read_data  : word returned by the memory controller
//   write_data : store data replicated onto every lane it may occupy
//   byte_mask  : active write lanes (0000 for loads)
//   load_data  : selected lane, sign/zero extended (0 for stores)
// ---------------------------------------------------------------------------
module lsu_align
  import trashbin_lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] store_data,
  input  logic [31:0] read_data,
  output logic [31:0] write_data,
  output logic [3:0]  byte_mask,
  output logic [31:0] load_data
);

  lsu_op_e     op_e;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign op_e    = lsu_op_e'(op);
  assign rd_half = byte_off[1] ? read_data[31:16] : read_data[15:0];

  always_comb begin
    rd_byte = read_data[7:0];
    case (byte_off)
      2'd0: rd_byte = read_data[7:0];
      2'd1: rd_byte = read_data[15:8];
      2'd2: rd_byte = read_data[23:16];
      2'd3: rd_byte = read_data[31:24];
      default: rd_byte = read_data[7:0];
    endcase
  end

  always_comb begin
    write_data = '0;
    byte_mask  = '0;
    load_data  = '0;
    case (op_e)
      OP_LB:  load_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LH:  load_data = {{16{rd_half[15]}}, rd_half};
      OP_LW:  load_data = read_data;
      OP_LBU: load_data = {24'd0, rd_byte};
      OP_LHU: load_data = {16'd0, rd_half};
      OP_SB: begin
        // Replicating onto all lanes lets the mask alone pick the target byte.
        write_data = {4{store_data[7:0]}};
        byte_mask  = 4'b0001 << byte_off;
      end
      OP_SH: begin
        write_data = {2{store_data[15:0]}};
        byte_mask  = byte_off[1] ? 4'b1100 : 4'b0011;
      end
      OP_SW: begin
        write_data = store_data;
        byte_mask  = 4'b1111;
      end
      default: begin
        write_data = '0;
        byte_mask  = '0;
        load_data  = '0;
      end
    endcase
  end

endmodule

// File: rtl/cpu_load_store_unit.sv
// ---------------------------------------------------------------------------
// cpu_load_store_unit
// Accepts one byte/half/word memory operation from the core at a time,
// checks alignment, issues a single registered bus request, waits for
// BusReady (bounded by TIMEOUT_CYCLES) and returns a one-cycle completion.
//   Core side : LsuValid, LsuOp, LsuAddress, LsuStoreData in;
//               LsuBusy, LsuDone, LsuLoadData, LsuFault out.
//   Bus side  : BusRequest, BusWrite, BusAddress, BusWriteData, BusByteMask
//               out (all registered); BusReady, BusReadData in.
//   CoreClock rising edge; CoreReset_n asynchronous, active-low.
// ---------------------------------------------------------------------------
module cpu_load_store_unit
  import trashbin_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CoreClock,
  input  logic        CoreReset_n,
  input  logic        LsuValid,
  input  logic [2:0]  LsuOp,
  input  logic [31:0] LsuAddress,
  input  logic [31:0] LsuStoreData,
  output logic        LsuBusy,
  output logic        LsuDone,
  output logic [31:0] LsuLoadData,
  output logic [1:0]  LsuFault,
  output logic        BusRequest,
  output logic        BusWrite,
  output logic [31:0] BusAddress,
  output logic [31:0] BusWriteData,
  output logic [3:0]  BusByteMask,
  input  logic        BusReady,
  input  logic [31:0] BusReadData
);

  // The counter only has to reach TIMEOUT_CYCLES-1: the request cycle in
  // which it holds that value is the last one allowed.
  localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_write_q, bus_write_d;
  logic [29:0]      bus_addr_q, bus_addr_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [3:0]       bus_mask_q, bus_mask_d;
  logic [31:0]      load_data_q, load_data_d;
  logic [1:0]       fault_q, fault_d;

  logic [2:0]       align_op;
  logic [1:0]       align_off;
  logic [31:0]      align_wdata;
  logic [3:0]       align_mask;
  logic [31:0]      align_load;

  // One aligner serves both directions: in IDLE it steers the incoming store,
  // afterwards it extracts the load lane from the captured operation.
  assign align_op  = (state_q == ST_IDLE) ? LsuOp : op_q;
  assign align_off = (state_q == ST_IDLE) ? LsuAddress[1:0] : off_q;

  lsu_align u_align (
    .op         (align_op),
    .byte_off   (align_off),
    .store_data (LsuStoreData),
    .read_data  (BusReadData),
    .write_data (align_wdata),
    .byte_mask  (align_mask),
    .load_data  (align_load)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_write_d = bus_write_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_mask_d  = bus_mask_q;
    load_data_d = load_data_q;
    fault_d     = fault_q;

    case (state_q)
      ST_IDLE: begin
        load_data_d = '0;
        fault_d     = FAULT_OK;
        if (LsuValid) begin
          op_d  = LsuOp;
          off_d = LsuAddress[1:0];
          if (is_misaligned(lsu_op_e'(LsuOp), LsuAddress[1:0])) begin
            fault_d = FAULT_MISALIGNED;
            state_d = ST_COMPLETE;
          end else begin
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_write_d = is_store_op(lsu_op_e'(LsuOp));
            bus_addr_d  = LsuAddress[31:2];
            bus_wdata_d = align_wdata;
            bus_mask_d  = align_mask;
            state_d     = ST_REQUEST;
          end
        end
      end

      ST_REQUEST: begin
        if (BusReady || (cnt_q == CNT_LAST)) begin
          // Stores see zero from the aligner, so no extra qualification.
          load_data_d = BusReady ? align_load : '0;
          fault_d     = BusReady ? FAULT_OK : FAULT_TIMEOUT;
          bus_req_d   = 1'b0;
          bus_write_d = 1'b0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
          bus_mask_d  = '0;
          state_d     = ST_COMPLETE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_COMPLETE: begin
        load_data_d = '0;
        fault_d     = FAULT_OK;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CoreClock or negedge CoreReset_n) begin
    if (!CoreReset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_write_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_mask_q  <= '0;
      load_data_q <= '0;
      fault_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_write_q <= bus_write_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_mask_q  <= bus_mask_d;
      load_data_q <= load_data_d;
      fault_q     <= fault_d;
    end
  end

  assign LsuBusy      = (state_q != ST_IDLE);
  assign LsuDone      = (state_q == ST_COMPLETE);
  assign LsuLoadData  = load_data_q;
  assign LsuFault     = fault_q;
  assign BusRequest   = bus_req_q;
  assign BusWrite     = bus_write_q;
  assign BusAddress   = {bus_addr_q, 2'b00};
  assign BusWriteData = bus_wdata_q;
  assign BusByteMask  = bus_mask_q;

endmodule

// File: tb/tb_cpu_load_store_unit.sv
module tb_cpu_load_store_unit;

  localparam int TO = 4;
  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3,
                         LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

  logic        CoreClock = 1'b0;
  logic        CoreReset_n = 1'b1;
  logic        LsuValid = 1'b0;
  logic [2:0]  LsuOp = 3'd0;
  logic [31:0] LsuAddress = 32'd0;
  logic [31:0] LsuStoreData = 32'd0;
  logic        LsuBusy, LsuDone;
  logic [31:0] LsuLoadData;
  logic [1:0]  LsuFault;
  logic        BusRequest, BusWrite;
  logic [31:0] BusAddress, BusWriteData;
  logic [3:0]  BusByteMask;
  logic        BusReady = 1'b0;
  logic [31:0] BusReadData = 32'd0;

  int checks = 0;
  int errors = 0;

  // Observations of the most recent transaction.
  int          obs_done_k, obs_req_cycles, obs_done_pulses;
  logic        obs_stable, obs_idle_after, obs_write;
  logic [31:0] obs_addr, obs_wdata, obs_data;
  logic [3:0]  obs_mask;
  logic [1:0]  obs_fault;

  cpu_load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .CoreClock    (CoreClock),
    .CoreReset_n  (CoreReset_n),
    .LsuValid     (LsuValid),
    .LsuOp        (LsuOp),
    .LsuAddress   (LsuAddress),
    .LsuStoreData (LsuStoreData),
    .LsuBusy      (LsuBusy),
    .LsuDone      (LsuDone),
    .LsuLoadData  (LsuLoadData),
    .LsuFault     (LsuFault),
    .BusRequest   (BusRequest),
    .BusWrite     (BusWrite),
    .BusAddress   (BusAddress),
    .BusWriteData (BusWriteData),
    .BusByteMask  (BusByteMask),
    .BusReady     (BusReady),
    .BusReadData  (BusReadData)
  );

  always #5 CoreClock = ~CoreClock;

  // Reference model: what the unit should do for one operation.
  function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] sdata, input logic [31:0] rdata,
                                output logic mis, output logic wr, output logic [3:0] mask,
                                output logic [31:0] wdata, output logic [31:0] ld);
    int size;
    logic sgn;
    logic [31:0] v;
    size = (op == LB || op == LBU || op == SB) ? 1 : (op == LH || op == LHU || op == SH) ? 2 : 4;
    sgn  = (op == LB || op == LH);
    wr   = (op == SB || op == SH || op == SW);
    mis  = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
    mask = wr ? 4'((((1 << size) - 1) << addr[1:0])) : 4'b0000;
    if (size == 1)      wdata = {24'd0, sdata[7:0]} * 32'h01010101;
    else if (size == 2) wdata = {16'd0, sdata[15:0]} * 32'h00010001;
    else                wdata = sdata;
    v = rdata >> (8 * addr[1:0]);
    if (size == 1) begin
      v = v & 32'hFF;
      if (sgn && v[7]) v = v | 32'hFFFFFF00;
    end else if (size == 2) begin
      v = v & 32'hFFFF;
      if (sgn && v[15]) v = v | 32'hFFFF0000;
    end
    ld = wr ? 32'd0 : v;
  endfunction

  // Presents one operation (unit must be idle) and plays the memory
  // controller: BusReady in request cycle delay+1, or never if delay < 0.
  task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input int delay, input logic [31:0] rdata);
    bit seen_done;
    obs_done_k = -1; obs_req_cycles = 0; obs_done_pulses = 0; obs_stable = 1'b1;
    obs_idle_after = 1'b0; obs_write = 1'b0; obs_addr = '0; obs_wdata = '0;
    obs_mask = '0; obs_data = '0; obs_fault = '0;
    seen_done = 1'b0;
    LsuValid = 1'b1; LsuOp = op; LsuAddress = addr; LsuStoreData = sdata;
    BusReady = 1'($urandom_range(0, 1));
    BusReadData = $urandom;
    @(posedge CoreClock); #1;
    LsuValid = 1'b0;
    LsuOp = 3'($urandom_range(0, 7)); LsuAddress = $urandom; LsuStoreData = $urandom;
    for (int k = 1; k <= TO + 6; k++) begin
      if (BusRequest) begin
        if (obs_req_cycles == 0) begin
          obs_addr = BusAddress; obs_write = BusWrite; obs_wdata = BusWriteData; obs_mask = BusByteMask;
        end else if (BusAddress !== obs_addr || BusWrite !== obs_write ||
                     BusWriteData !== obs_wdata || BusByteMask !== obs_mask) begin
          obs_stable = 1'b0;
        end
        obs_req_cycles++;
      end
      if (LsuDone) begin
        obs_done_pulses++;
        if (!seen_done) begin
          obs_done_k = k; obs_data = LsuLoadData; obs_fault = LsuFault;
        end
        seen_done = 1'b1;
      end
      if (seen_done && !LsuDone) begin
        obs_idle_after = !LsuBusy;
        break;
      end
      if (BusRequest) begin
        BusReady = (delay >= 0 && obs_req_cycles - 1 == delay);
        BusReadData = BusReady ? rdata : $urandom;
      end else begin
        BusReady = 1'($urandom_range(0, 1));
        BusReadData = $urandom;
      end
      @(posedge CoreClock); #1;
    end
    BusReady = 1'b0;
  endtask

  task automatic test_reset();
    #1 CoreReset_n = 1'b0;
    #12;
    checks++;
    if ({LsuBusy, LsuDone, LsuLoadData, LsuFault, BusRequest, BusWrite, BusAddress,
         BusWriteData, BusByteMask} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b req=%b addr=%h want all zero",
               LsuBusy, LsuDone, BusRequest, BusAddress);
    end
    @(negedge CoreClock);
    CoreReset_n = 1'b1;
    // First rising edge with reset high must already accept.
    run_op(LW, 32'h0000_0040, 32'd0, 0, 32'h1234_5678);
    checks++;
    if (obs_done_k !== 2) begin
      errors++; $display("FAIL first_accept_latency got %0d want 2", obs_done_k);
    end
    checks++;
    if (obs_data !== 32'h1234_5678) begin
      errors++; $display("FAIL first_accept_data got %h want 12345678", obs_data);
    end
  endtask

  task automatic test_lw_basic();
    run_op(LW, 32'h0000_0100, 32'd0, 0, 32'hDEAD_BEEF);
    checks++;
    if (obs_done_k !== 2) begin
      errors++; $display("FAIL lw_latency got %0d want 2", obs_done_k);
    end
    checks++;
    if (obs_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL lw_data got %h want deadbeef", obs_data);
    end
    checks++;
    if (obs_fault !== 2'd0) begin
      errors++; $display("FAIL lw_fault got %0d want 0", obs_fault);
    end
    checks++;
    if (obs_addr !== 32'h100 || obs_write !== 1'b0 || obs_mask !== 4'b0000) begin
      errors++; $display("FAIL lw_bus got addr=%h wr=%b mask=%b want 100/0/0000", obs_addr, obs_write, obs_mask);
    end
  endtask

  task automatic test_lb_lbu();
    run_op(LB, 32'h0000_0103, 32'd0, 0, 32'h8011_2233);
    checks++;
    if (obs_addr !== 32'h100) begin
      errors++; $display("FAIL lb_addr got %h want 00000100", obs_addr);
    end
    checks++;
    if (obs_data !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL lb_data got %h want ffffff80", obs_data);
    end
    run_op(LBU, 32'h0000_0103, 32'd0, 0, 32'h8011_2233);
    checks++;
    if (obs_data !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu_data got %h want 00000080", obs_data);
    end
  endtask

  task automatic test_sh_delay();
    run_op(SH, 32'h0000_0202, 32'h0000_ABCD, 3, 32'hFFFF_FFFF);
    checks++;
    if (obs_req_cycles !== 4 || obs_stable !== 1'b1) begin
      errors++; $display("FAIL sh_hold got cycles=%0d stable=%b want 4/1", obs_req_cycles, obs_stable);
    end
    checks++;
    if (obs_wdata !== 32'hABCD_ABCD || obs_mask !== 4'b1100 || obs_write !== 1'b1) begin
      errors++; $display("FAIL sh_bus got wdata=%h mask=%b wr=%b want abcdabcd/1100/1", obs_wdata, obs_mask, obs_write);
    end
    checks++;
    if (obs_done_k !== 5 || obs_fault !== 2'd0 || obs_data !== 32'd0) begin
      errors++; $display("FAIL sh_done got k=%0d fault=%0d data=%h want 5/0/0", obs_done_k, obs_fault, obs_data);
    end
  endtask

  task automatic test_misaligned();
    run_op(LW, 32'h0000_0101, 32'd0, 0, 32'h5555_5555);
    checks++;
    if (obs_req_cycles !== 0) begin
      errors++; $display("FAIL mis_no_bus got %0d request cycles want 0", obs_req_cycles);
    end
    checks++;
    if (obs_done_k !== 1 || obs_fault !== 2'd1) begin
      errors++; $display("FAIL mis_done got k=%0d fault=%0d want 1/1", obs_done_k, obs_fault);
    end
  endtask

  task automatic test_timeout();
    run_op(SW, 32'h0000_0300, 32'h0BAD_F00D, -1, 32'd0);
    checks++;
    if (obs_req_cycles !== TO) begin
      errors++; $display("FAIL to_req_cycles got %0d want %0d", obs_req_cycles, TO);
    end
    checks++;
    if (obs_done_k !== TO + 1 || obs_fault !== 2'd2) begin
      errors++; $display("FAIL to_done got k=%0d fault=%0d want %0d/2", obs_done_k, obs_fault, TO + 1);
    end
    checks++;
    if (obs_done_pulses !== 1 || obs_idle_after !== 1'b1) begin
      errors++; $display("FAIL to_pulse got pulses=%0d idle=%b want 1/1", obs_done_pulses, obs_idle_after);
    end
  endtask

  task automatic test_reset_mid();
    bit done_seen;
    LsuValid = 1'b1; LsuOp = LW; LsuAddress = 32'h0000_0400; BusReady = 1'b0;
    @(posedge CoreClock); #1;
    LsuValid = 1'b0;
    @(posedge CoreClock); #1;
    checks++;
    if (BusRequest !== 1'b1) begin
      errors++; $display("FAIL rst_mid_req_before got %b want 1", BusRequest);
    end
    CoreReset_n = 1'b0;
    #1;
    checks++;
    if (BusRequest !== 1'b0 || LsuBusy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async got req=%b busy=%b want 0/0", BusRequest, LsuBusy);
    end
    done_seen = 1'b0;
    repeat (3) begin
      @(posedge CoreClock); #1;
      if (LsuDone) done_seen = 1'b1;
    end
    @(negedge CoreClock);
    CoreReset_n = 1'b1;
    checks++;
    if (done_seen !== 1'b0) begin
      errors++; $display("FAIL rst_mid_no_done got done=%b want 0", done_seen);
    end
    run_op(LW, 32'h0000_0500, 32'd0, 1, 32'hCAFE_0001);
    checks++;
    if (obs_done_k !== 3 || obs_data !== 32'hCAFE_0001 || obs_fault !== 2'd0) begin
      errors++; $display("FAIL rst_mid_next got k=%0d data=%h fault=%0d want 3/cafe0001/0", obs_done_k, obs_data, obs_fault);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] addr, sdata, rdata;
    int          delay, exp_k, exp_req;
    logic        e_mis, e_wr;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata, e_ld, e_data;
    logic [1:0]  e_fault;
    for (int i = 0; i < 60; i++) begin
      op    = 3'($urandom_range(0, 7));
      addr  = $urandom;
      sdata = $urandom;
      rdata = $urandom;
      delay = $urandom_range(0, 5);
      if (delay >= TO) delay = -1;
      model(op, addr, sdata, rdata, e_mis, e_wr, e_mask, e_wdata, e_ld);
      run_op(op, addr, sdata, delay, rdata);
      if (e_mis) begin
        exp_req = 0; exp_k = 1; e_fault = 2'd1; e_data = 32'd0;
      end else if (delay < 0) begin
        exp_req = TO; exp_k = TO + 1; e_fault = 2'd2; e_data = 32'd0;
      end else begin
        exp_req = delay + 1; exp_k = delay + 2; e_fault = 2'd0; e_data = e_ld;
      end
      checks++;
      if (obs_done_k !== exp_k || obs_req_cycles !== exp_req || obs_done_pulses !== 1 || obs_idle_after !== 1'b1) begin
        errors++;
        $display("FAIL rnd_timing[%0d] op=%0d addr=%h got k=%0d req=%0d pulses=%0d want k=%0d req=%0d pulses=1",
                 i, op, addr, obs_done_k, obs_req_cycles, obs_done_pulses, exp_k, exp_req);
      end
      checks++;
      if (obs_fault !== e_fault || obs_data !== e_data) begin
        errors++;
        $display("FAIL rnd_result[%0d] op=%0d addr=%h got fault=%0d data=%h want fault=%0d data=%h",
                 i, op, addr, obs_fault, obs_data, e_fault, e_data);
      end
      if (!e_mis) begin
        checks++;
        if (obs_addr !== {addr[31:2], 2'b00} || obs_write !== e_wr || obs_mask !== e_mask ||
            (e_wr && obs_wdata !== e_wdata) || obs_stable !== 1'b1) begin
          errors++;
          $display("FAIL rnd_bus[%0d] op=%0d got addr=%h wr=%b mask=%b wdata=%h stable=%b want addr=%h wr=%b mask=%b wdata=%h",
                   i, op, obs_addr, obs_write, obs_mask, obs_wdata, obs_stable,
                   {addr[31:2], 2'b00}, e_wr, e_mask, e_wdata);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw_basic();
    test_lb_lbu();
    test_sh_delay();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
